// File: rtl/bus_arbiter_rr.sv
// Registered one-hot bus arbiter (round-robin or fixed priority) with time-slice
// preemption, per-owner lock and a forced idle turnaround cycle between owners.
module bus_arbiter_rr #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int RR_MODE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     bus_busy,
  output logic                     preempt
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t              state, state_nxt;
  logic [N_REQ-1:0]    grant_nxt;
  logic [ID_W-1:0]     grant_id_nxt;
  logic                preempt_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_nxt;

  logic [ID_W-1:0]     scan_base;
  logic [ID_W-1:0]     cand;
  logic [ID_W-1:0]     win_id;
  logic [N_REQ-1:0]    win_hot;
  logic                win_found;
  logic [ID_W-1:0]     win_next_ptr;
  logic                owner_req;
  logic                competitor;
  logic                owner_locked;
  logic                slice_expired;

  // Fixed priority is just a round-robin scan that always starts at index 0.
  assign scan_base = (RR_MODE != 0) ? rr_ptr : '0;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_hot   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(scan_base) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    win_hot[win_id] = win_found;
  end

  assign win_next_ptr = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;

  // While in GRANT the registered one-hot grant doubles as the owner mask.
  assign owner_req     = |(req & grant);
  assign competitor    = |(req & ~grant);
  assign owner_locked  = |(lock & grant);
  assign slice_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) &&
                         !owner_locked && competitor;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    grant_id_nxt = grant_id;
    preempt_nxt  = 1'b0;
    hold_nxt     = hold_cnt;
    rr_ptr_nxt   = rr_ptr;
    case (state)
      IDLE, TURN: begin
        grant_nxt = '0;
        state_nxt = IDLE;
        if (win_found) begin
          state_nxt    = GRANT;
          grant_nxt    = win_hot;
          grant_id_nxt = win_id;
          hold_nxt     = HOLD_W'(1);
          if (RR_MODE != 0) rr_ptr_nxt = win_next_ptr;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_nxt = TURN;
          grant_nxt = '0;
        end else if (slice_expired) begin
          state_nxt   = TURN;
          grant_nxt   = '0;
          preempt_nxt = 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_MAX)) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      bus_busy <= 1'b0;
      preempt  <= 1'b0;
      hold_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_id <= grant_id_nxt;
      bus_busy <= |grant_nxt;
      preempt  <= preempt_nxt;
      hold_cnt <= hold_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: a round-robin and a fixed-priority instance share inputs
// and are compared every cycle against an owner/slice-level model, plus literal checks.
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic         tbActive = 1'b0;

  logic [N-1:0] grantRr, grantFp;
  logic [1:0]   idRr, idFp;
  logic         busyRr, busyFp, preRr, preFp;

  int checks = 0;
  int failures = 0;

  bus_arbiter_rr #(.N_REQ(N), .MAX_HOLD(MH), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .grant(grantRr), .grant_id(idRr), .bus_busy(busyRr), .preempt(preRr));

  bus_arbiter_rr #(.N_REQ(N), .MAX_HOLD(MH), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .grant(grantFp), .grant_id(idFp), .bus_busy(busyFp), .preempt(preFp));

  always #5 clk = ~clk;

  // Model: unit 0 is round-robin, unit 1 fixed priority; owner -1 means bus free.
  int           mOwner [2];
  int           mHeld  [2];
  int           mPtr   [2];
  logic [N-1:0] eGrant [2];
  logic [1:0]   eId    [2];
  logic         eBusy  [2];
  logic         ePre   [2];

  task automatic modelEdge(input int u);
    int others;
    int pick;
    int c;
    ePre[u] = 1'b0;
    if (mOwner[u] >= 0) begin
      others = 0;
      for (int k = 0; k < N; k++) if (k != mOwner[u] && req[k]) others++;
      if (!req[mOwner[u]]) begin
        mOwner[u] = -1;
      end else if (MH > 0 && mHeld[u] >= MH && !lock[mOwner[u]] && others > 0) begin
        mOwner[u] = -1;
        ePre[u] = 1'b1;
      end else if (mHeld[u] < MH) begin
        mHeld[u]++;
      end
    end else if (req != '0) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        c = (u == 0) ? (mPtr[u] + k) % N : k;
        if (pick < 0 && req[c]) pick = c;
      end
      mOwner[u] = pick;
      mHeld[u] = 1;
      mPtr[u] = (pick + 1) % N;
    end
    eGrant[u] = (mOwner[u] >= 0) ? 4'(1 << mOwner[u]) : 4'b0000;
    if (mOwner[u] >= 0) eId[u] = 2'(mOwner[u]);
    eBusy[u] = (mOwner[u] >= 0);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        mOwner[u] = -1; mHeld[u] = 0; mPtr[u] = 0;
        eGrant[u] = '0; eId[u] = '0; eBusy[u] = 1'b0; ePre[u] = 1'b0;
      end
    end else begin
      for (int u = 0; u < 2; u++) modelEdge(u);
    end
  end

  task automatic compareUnit(input int u, input logic [N-1:0] g, input logic [1:0] id,
                             input logic busy, input logic p);
    checks++;
    if (g !== eGrant[u] || id !== eId[u] || busy !== eBusy[u] || p !== ePre[u]) begin
      failures++;
      $display("[TB] FAIL model_unit%0d t=%0t: grant=%b id=%0d busy=%b preempt=%b, required grant=%b id=%0d busy=%b preempt=%b",
               u, $time, g, id, busy, p, eGrant[u], eId[u], eBusy[u], ePre[u]);
    end
  endtask

  // Continuous comparison of both instances, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && tbActive) begin
      compareUnit(0, grantRr, idRr, busyRr, preRr);
      compareUnit(1, grantFp, idFp, busyFp, preFp);
    end
  end

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l);
    @(negedge clk);
    req = r;
    lock = l;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int u, input logic [N-1:0] expG,
                             input logic expP);
    logic [N-1:0] g;
    logic p, b;
    g = (u == 0) ? grantRr : grantFp;
    p = (u == 0) ? preRr : preFp;
    b = (u == 0) ? busyRr : busyFp;
    checks++;
    if (g !== expG || p !== expP || b !== (|expG)) begin
      failures++;
      $display("[TB] FAIL %s: grant=%b preempt=%b busy=%b, required grant=%b preempt=%b busy=%b",
               name, g, p, b, expG, expP, |expG);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    lock = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [3:0] T2REQ [13] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1111, 4'b1101,
                                        4'b1111, 4'b1111, 4'b1011, 4'b1111, 4'b1111, 4'b0111,
                                        4'b1111};
  localparam logic [3:0] T2GNT [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                        4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                                        4'b0001};
  localparam logic [3:0] T5REQ [10] = '{4'b0110, 4'b0110, 4'b0100, 4'b0110, 4'b0110, 4'b0100,
                                        4'b0100, 4'b0110, 4'b0010, 4'b0110};
  localparam logic [3:0] T5GNT [10] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                        4'b0100, 4'b0100, 4'b0000, 4'b0010};

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_rr", 0, 4'b0000, 1'b0);
    checkOutput("reset_fp", 1, 4'b0000, 1'b0);
    checks++;
    if (idRr !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_id: grant_id=%0d, required 0", idRr);
    end
    tbActive = 1'b1;

    // First grant one edge after request
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b0001, 4'b0000);
    checkOutput("first_grant_rr", 0, 4'b0001, 1'b0);
    checkOutput("first_grant_fp", 1, 4'b0001, 1'b0);
    checks++;
    if (idRr !== 2'd0) begin
      failures++;
      $display("[TB] FAIL first_grant_id: grant_id=%0d, required 0", idRr);
    end

    // Round-robin rotation with turnaround gaps
    resetDut();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(T2REQ[i], 4'b0000);
      checkOutput($sformatf("rotate_%0d", i), 0, T2GNT[i], 1'b0);
    end

    // Time-slice preemption
    resetDut();
    applyStimulus(4'b0001, 4'b0000);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0101, 4'b0000);
    checkOutput("slice_hold4", 0, 4'b0001, 1'b0);
    applyStimulus(4'b0101, 4'b0000);
    checkOutput("slice_preempt", 0, 4'b0000, 1'b1);
    applyStimulus(4'b0101, 4'b0000);
    checkOutput("slice_next_owner", 0, 4'b0100, 1'b0);

    // Lock blocks preemption; unlocking preempts on the next edge
    resetDut();
    applyStimulus(4'b0001, 4'b0001);
    for (int i = 0; i < 22; i++) begin
      applyStimulus(4'b0101, 4'b0001);
      checkOutput($sformatf("locked_%0d", i), 0, 4'b0001, 1'b0);
    end
    applyStimulus(4'b0101, 4'b0000);
    checkOutput("unlock_preempt", 0, 4'b0000, 1'b1);
    applyStimulus(4'b0101, 4'b0000);
    checkOutput("unlock_next_owner", 0, 4'b0100, 1'b0);

    // Fixed priority: device 2 only wins while device 1 is not requesting
    resetDut();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(T5REQ[i], 4'b0000);
      checkOutput($sformatf("fixed_%0d", i), 1, T5GNT[i], 1'b0);
    end

    // Asynchronous reset mid-grant clears outputs and the round-robin pointer
    resetDut();
    applyStimulus(4'b0010, 4'b0000);
    applyStimulus(4'b0010, 4'b0000);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_rr", 0, 4'b0000, 1'b0);
    checkOutput("async_reset_fp", 1, 4'b0000, 1'b0);
    @(negedge clk);
    req = 4'b1000;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("after_reset_1000", 0, 4'b1000, 1'b0);
    #2 rst = 1'b1;
    #1;
    @(negedge clk);
    req = 4'b1010;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("after_reset_ptr0", 0, 4'b0010, 1'b0);

    applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
